// File: rtl/remote_comm.sv
// remote_comm: host-side UART link; sends a 16-bit command as two 8N1 bytes (high first)
// and receives single response bytes on an independent receiver.
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);
    localparam int CW = $clog2(BAUD_DIV);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA} rx_state_t;

    tx_state_t     tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic [15:0]   cmd_q, cmd_d;
    logic          tx_q, tx_d, sent_q, sent_d;

    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [3:0]    rx_bit_q, rx_bit_d;
    logic [2:0]    rx_sync_q;
    logic [7:0]    sh_q, sh_d, resp_q, resp_d;
    logic          rdy_q, rdy_d;

    logic       accept, baud_end, frame_end, rx_s, rx_prev;
    logic [9:0] frame;

    assign accept    = tx_state_q == IDLE && send_cmd;
    assign baud_end  = tx_cnt_q == CW'(BAUD_DIV - 1);
    assign frame_end = baud_end && tx_bit_q == 4'd9;
    assign frame     = {1'b1, tx_state_q == HIGH ? cmd_q[15:8] : cmd_q[7:0], 1'b0};
    assign rx_s      = rx_sync_q[1];
    assign rx_prev   = rx_sync_q[2];

    assign TX       = tx_q;
    assign cmd_sent = sent_q;
    assign resp_rdy = rdy_q;
    assign resp     = resp_q;

    // TX is registered, so the line lags the FSM's bit position by one cycle
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        cmd_d      = cmd_q;
        sent_d     = sent_q;
        tx_d       = (tx_state_q == HIGH || tx_state_q == LOW) ? frame[tx_bit_q] : 1'b1;
        case (tx_state_q)
            IDLE: if (send_cmd) begin
                tx_state_d = HIGH;
                cmd_d      = cmd;
                sent_d     = 1'b0;
                tx_cnt_d   = '0;
                tx_bit_d   = '0;
            end
            HIGH, LOW: begin
                tx_cnt_d = baud_end ? '0 : tx_cnt_q + CW'(1);
                tx_bit_d = frame_end ? 4'd0 : (baud_end ? tx_bit_q + 4'd1 : tx_bit_q);
                if (frame_end) tx_state_d = tx_state_q == HIGH ? LOW : DONE;
            end
            default: begin
                sent_d     = 1'b1;
                tx_state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        sh_d       = sh_q;
        resp_d     = resp_q;
        rdy_d      = accept ? 1'b0 : rdy_q;
        case (rx_state_q)
            R_IDLE: if (rx_prev && !rx_s) begin
                rx_state_d = R_START;
                rx_cnt_d   = '0;
                rdy_d      = 1'b0;
            end
            R_START: if (rx_cnt_q == CW'(BAUD_DIV / 2 - 1)) begin
                rx_state_d = rx_s ? R_IDLE : R_DATA;
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
            end
            default: if (rx_cnt_q == CW'(BAUD_DIV - 1)) begin
                rx_cnt_d = '0;
                if (rx_bit_q == 4'd8) begin
                    resp_d     = sh_q;
                    rdy_d      = 1'b1;
                    rx_state_d = R_IDLE;
                end else begin
                    sh_d     = {rx_s, sh_q[7:1]};
                    rx_bit_d = rx_bit_q + 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            cmd_q      <= '0;
            tx_q       <= 1'b1;
            sent_q     <= 1'b0;
            rx_state_q <= R_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_sync_q  <= 3'b111;
            sh_q       <= '0;
            resp_q     <= '0;
            rdy_q      <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            cmd_q      <= cmd_d;
            tx_q       <= tx_d;
            sent_q     <= sent_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sync_q  <= {rx_sync_q[1:0], RX};
            sh_q       <= sh_d;
            resp_q     <= resp_d;
            rdy_q      <= rdy_d;
        end
    end
endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: scoreboard bench; a UART decoder on TX and a monitor on resp_rdy
// pop expected bytes queued by the directed stimulus.
module tb_remote_comm;
    localparam int B = 16;

    logic        clk = 0, rst_n = 0, rx_drv = 1, loop = 0, send_cmd = 0;
    logic [15:0] cmd = '0;
    logic        TX, cmd_sent, resp_rdy, rx;
    logic [7:0]  resp;
    logic [7:0]  tx_exp[$], resp_exp[$];
    int          n_cmp = 0, n_err = 0;

    assign rx = loop ? TX : rx_drv;

    remote_comm #(.BAUD_DIV(B)) dut (
        .clk(clk), .rst_n(rst_n), .RX(rx), .TX(TX), .cmd(cmd), .send_cmd(send_cmd),
        .cmd_sent(cmd_sent), .resp_rdy(resp_rdy), .resp(resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [7:0] val);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got %0h, required nothing", name, val);
    endtask

    task automatic wait_live(input int n, inout bit ok);
        for (int c = 0; c < n && ok; c++) begin
            @(negedge clk);
            ok = rst_n;
        end
    endtask

    // UART decoder on TX: samples each bit at its centre, abandons the frame on reset
    initial begin
        logic [9:0] f;
        bit ok;
        forever begin
            @(negedge clk);
            if (rst_n && TX === 1'b0) begin
                ok = 1;
                wait_live(B / 2, ok);
                f[0] = TX;
                for (int m = 1; m < 10; m++) begin
                    wait_live(B, ok);
                    f[m] = TX;
                end
                if (ok) begin
                    if (tx_exp.size() == 0) unexpected("tx_extra_byte", f[8:1]);
                    else check("tx_frame", {22'd0, f}, {22'd0, 1'b1, tx_exp.pop_front(), 1'b0});
                end
            end
        end
    end

    initial begin
        logic prev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (resp_rdy && !prev) begin
                if (resp_exp.size() == 0) unexpected("resp_extra", resp);
                else check("resp_byte", {24'd0, resp}, {24'd0, resp_exp.pop_front()});
            end
            prev = resp_rdy;
        end
    end

    task automatic pulse(input logic [15:0] c);
        @(negedge clk);
        cmd = c;
        send_cmd = 1;
        @(negedge clk);
        send_cmd = 0;
    endtask

    task automatic wait_sent(input string name);
        int cnt = 0;
        while (!cmd_sent && cnt < 25 * B) begin
            @(negedge clk);
            cnt++;
        end
        check(name, {31'd0, cmd_sent}, 32'd1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (B) @(negedge clk);
        end
    endtask

    initial begin
        int cnt, lows;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("rst_tx", {31'd0, TX}, 32'd1);
        check("rst_cmd_sent", {31'd0, cmd_sent}, 32'd0);
        check("rst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
        check("rst_resp", {24'd0, resp}, 32'd0);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (!TX) lows++;
        end
        check("idle_tx_quiet", lows, 0);

        tx_exp.push_back(8'h20);
        tx_exp.push_back(8'h00);
        pulse(16'h2000);
        check("tx_before_start", {31'd0, TX}, 32'd1);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) check("tx_start_bit", {31'd0, TX}, 32'd0);
        end while (!cmd_sent && cnt < 25 * B);
        check("sent_latency", cnt, 20 * B + 1);
        check("tx_idle_after", {31'd0, TX}, 32'd1);

        repeat (5) @(negedge clk);
        resp_exp.push_back(8'hA5);
        cnt = 0;
        fork
            send_rx(8'hA5);
            while (!resp_rdy && cnt < 12 * B) begin
                @(negedge clk);
                cnt++;
            end
        join
        check("resp_in_time", {31'd0, cnt <= 10 * B + 3}, 32'd1);
        check("resp_rdy_held", {31'd0, resp_rdy}, 32'd1);
        tx_exp.push_back(8'h00);
        tx_exp.push_back(8'h01);
        pulse(16'h0001);
        check("rdy_cleared_by_send", {31'd0, resp_rdy}, 32'd0);
        wait_sent("sent_0001");

        tx_exp.push_back(8'h12);
        tx_exp.push_back(8'h34);
        pulse(16'h1234);
        repeat (3 * B) @(negedge clk);
        cmd = 16'hFFFF;
        send_cmd = 1;
        repeat (2 * B) @(negedge clk);
        send_cmd = 0;
        wait_sent("sent_busy");
        repeat (12 * B) @(negedge clk);
        check("busy_two_bytes_only", tx_exp.size(), 0);
        check("sent_holds", {31'd0, cmd_sent}, 32'd1);

        rx_drv = 0;
        @(negedge clk);
        rx_drv = 1;
        repeat (12 * B) @(negedge clk);
        check("glitch_no_rdy", {31'd0, resp_rdy}, 32'd0);
        check("glitch_resp_hold", {24'd0, resp}, 32'h A5);

        loop = 1;
        tx_exp.push_back(8'hA5);
        tx_exp.push_back(8'h5A);
        resp_exp.push_back(8'hA5);
        resp_exp.push_back(8'h5A);
        pulse(16'hA55A);
        wait_sent("sent_loop");
        repeat (B) @(negedge clk);
        loop = 0;
        check("loop_both_resp", resp_exp.size(), 0);
        check("loop_last_resp", {24'd0, resp}, 32'h5A);

        tx_exp.push_back(8'h3C);
        tx_exp.push_back(8'h96);
        pulse(16'h3C96);
        repeat (13 * B) @(negedge clk);
        rst_n = 0;
        #1;
        check("midrst_tx", {31'd0, TX}, 32'd1);
        check("midrst_cmd_sent", {31'd0, cmd_sent}, 32'd0);
        check("midrst_resp_rdy", {31'd0, resp_rdy}, 32'd0);
        check("midrst_resp", {24'd0, resp}, 32'd0);
        tx_exp.delete();
        repeat (3) @(negedge clk);
        rst_n = 1;
        lows = 0;
        repeat (3 * B) begin
            @(negedge clk);
            if (!TX) lows++;
        end
        check("no_retransmit", lows, 0);
        tx_exp.push_back(8'hC3);
        tx_exp.push_back(8'h5A);
        pulse(16'hC35A);
        wait_sent("sent_after_reset");
        repeat (B) @(negedge clk);
        check("tx_queue_drained", tx_exp.size(), 0);
        check("resp_queue_drained", resp_exp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
